// File: rtl/tl_pkg.sv
// Shared types and width helpers for the multi-phase traffic controller.
package tl_pkg;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2,
      FLASH   = 2'd3
   } tl_state_t;

   function automatic int tl_max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // One spare bit so the longest duration never wraps the counter before its compare.
   function automatic int tl_tmr_w(input int max_dur);
      return $clog2(max_dur) + 1;
   endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-state up-timer: cleared on state entry, done flags the last cycle of a DUR-cycle state.
module tl_phase_timer #(
   parameter int TMR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [TMR_W-1:0] dur,
   output logic [TMR_W-1:0] tmr,
   output logic             done
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      tmr <= '0;
      else if (clr)  tmr <= '0;
      else           tmr <= tmr + TMR_W'(1);
   end

   assign done = (tmr == dur - TMR_W'(1));

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Round-robin N-phase intersection controller with pedestrian green cut and night flash.
//  state   | meaning
//  ALL_RED | clearance, every phase red; picks FLASH or next GREEN on exit
//  GREEN   | active phase green + walk; may be cut by another phase's request
//  YELLOW  | active phase yellow
//  FLASH   | all yellows flash, no red/green; leaves only at a toggle boundary
module multi_phase_traffic_ctrl
   import tl_pkg::*;
#(
   parameter int N_PHASE       = 2,
   parameter int GREEN_CYC     = 8,
   parameter int MIN_GREEN_CYC = 4,
   parameter int YELLOW_CYC    = 3,
   parameter int ALLRED_CYC    = 2,
   parameter int FLASH_CYC     = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flash_en,
   input  logic [N_PHASE-1:0]         ped_req,
   output logic [N_PHASE-1:0]         lamp_r,
   output logic [N_PHASE-1:0]         lamp_y,
   output logic [N_PHASE-1:0]         lamp_g,
   output logic [N_PHASE-1:0]         walk,
   output logic [$clog2(N_PHASE)-1:0] phase,
   output logic                       flashing
);

   localparam int PH_W  = $clog2(N_PHASE);
   localparam int TMR_W = tl_tmr_w(tl_max4(GREEN_CYC, YELLOW_CYC, ALLRED_CYC, FLASH_CYC));

   if (N_PHASE < 2) begin : g_chk_nphase
      $error("N_PHASE must be at least 2");
   end
   if (GREEN_CYC < 1 || YELLOW_CYC < 1 || ALLRED_CYC < 1 || FLASH_CYC < 1 || MIN_GREEN_CYC < 1)
   begin : g_chk_dur
      $error("all durations must be at least 1");
   end
   if (MIN_GREEN_CYC > GREEN_CYC) begin : g_chk_min
      $error("MIN_GREEN_CYC must not exceed GREEN_CYC");
   end

   tl_state_t           state, state_nx;
   logic [PH_W-1:0]     phase_nx, phase_inc;
   logic [N_PHASE-1:0]  pending, pending_nx;
   logic [N_PHASE-1:0]  phase_oh, phase_nx_oh;
   logic                flash_lit, flash_lit_nx;
   logic                started, started_nx;
   logic                tmr_clr, done, cut;
   logic [TMR_W-1:0]    tmr, dur;

   tl_phase_timer #(.TMR_W(TMR_W)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .dur  (dur),
      .tmr  (tmr),
      .done (done)
   );

   always_comb begin
      dur = TMR_W'(ALLRED_CYC);
      case (state)
         GREEN:   dur = TMR_W'(GREEN_CYC);
         YELLOW:  dur = TMR_W'(YELLOW_CYC);
         FLASH:   dur = TMR_W'(FLASH_CYC);
         default: dur = TMR_W'(ALLRED_CYC);
      endcase
   end

   assign phase_oh    = {{(N_PHASE-1){1'b0}}, 1'b1} << phase;
   assign phase_nx_oh = {{(N_PHASE-1){1'b0}}, 1'b1} << phase_nx;
   assign phase_inc   = (phase == PH_W'(N_PHASE-1)) ? '0 : phase + PH_W'(1);
   assign cut         = (tmr >= TMR_W'(MIN_GREEN_CYC-1)) && |(pending & ~phase_oh);

   always_comb begin
      state_nx     = state;
      phase_nx     = phase;
      flash_lit_nx = flash_lit;
      started_nx   = started;
      tmr_clr      = 1'b0;
      case (state)
         ALL_RED: if (done) begin
            tmr_clr    = 1'b1;
            started_nx = 1'b1;
            if (flash_en) begin
               state_nx     = FLASH;
               flash_lit_nx = 1'b1;
            end else begin
               state_nx = GREEN;
               // The very first green after reset is phase 0 rather than phase+1.
               phase_nx = started ? phase_inc : '0;
            end
         end
         GREEN: if (done || cut) begin
            state_nx = YELLOW;
            tmr_clr  = 1'b1;
         end
         YELLOW: if (done) begin
            state_nx = ALL_RED;
            tmr_clr  = 1'b1;
         end
         FLASH: if (done) begin
            tmr_clr = 1'b1;
            if (!flash_en) state_nx = ALL_RED;
            else           flash_lit_nx = ~flash_lit;
         end
         default: begin
            state_nx = ALL_RED;
            tmr_clr  = 1'b1;
         end
      endcase

      pending_nx = pending | (ped_req & ~((state == GREEN) ? phase_oh : '0));
      if (state != GREEN && state_nx == GREEN) pending_nx = pending_nx & ~phase_nx_oh;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ALL_RED;
         phase     <= '0;
         pending   <= '0;
         flash_lit <= 1'b0;
         started   <= 1'b0;
      end else begin
         state     <= state_nx;
         phase     <= phase_nx;
         pending   <= pending_nx;
         flash_lit <= flash_lit_nx;
         started   <= started_nx;
      end
   end

   always_comb begin
      lamp_r   = '1;
      lamp_y   = '0;
      lamp_g   = '0;
      walk     = '0;
      flashing = 1'b0;
      case (state)
         GREEN: begin
            lamp_r = ~phase_oh;
            lamp_g = phase_oh;
            walk   = phase_oh;
         end
         YELLOW: begin
            lamp_r = ~phase_oh;
            lamp_y = phase_oh;
         end
         FLASH: begin
            lamp_r   = '0;
            lamp_y   = {N_PHASE{flash_lit}};
            flashing = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Randomized scoreboard bench for multi_phase_traffic_ctrl against a timing-rule reference model.
module tb_multi_phase_traffic_ctrl;

   localparam int NP = 3;
   localparam int GC = 8;
   localparam int MG = 4;
   localparam int YC = 3;
   localparam int AC = 2;
   localparam int FC = 4;
   localparam int PW = $clog2(NP);
   localparam int OW = 4*NP + PW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flash_en = 1'b0;
   logic [NP-1:0] ped_req = '0;
   logic [NP-1:0] lamp_r, lamp_y, lamp_g, walk;
   logic [PW-1:0] phase;
   logic          flashing;

   multi_phase_traffic_ctrl #(
      .N_PHASE(NP), .GREEN_CYC(GC), .MIN_GREEN_CYC(MG),
      .YELLOW_CYC(YC), .ALLRED_CYC(AC), .FLASH_CYC(FC)
   ) dut (
      .clk(clk), .rst(rst), .flash_en(flash_en), .ped_req(ped_req),
      .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g), .walk(walk),
      .phase(phase), .flashing(flashing)
   );

   initial forever #5 clk = ~clk;

   typedef enum int {M_RED, M_GRN, M_YEL, M_FLS} mst_t;
   typedef struct {logic [OW-1:0] v; int c;} exp_t;
   typedef struct {int cycles; int ped_pct; int flash_pct; bit rst_yel;} seg_t;

   mst_t m_st;
   int   m_ph, m_age;
   bit   m_started, m_lit;
   bit   m_pend[NP];

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t exp_q[$];

   function automatic void model_reset();
      m_st = M_RED; m_ph = 0; m_age = 0; m_started = 0; m_lit = 0;
      for (int i = 0; i < NP; i++) m_pend[i] = 0;
   endfunction

   function automatic logic [OW-1:0] model_out();
      logic [NP-1:0] r, y, g, oh;
      bit fl;
      oh = NP'(1) << m_ph;
      r = '1; y = '0; g = '0; fl = 0;
      case (m_st)
         M_GRN: begin g = oh; r = ~oh; end
         M_YEL: begin y = oh; r = ~oh; end
         M_FLS: begin r = '0; y = m_lit ? '1 : '0; fl = 1; end
         default: ;
      endcase
      return {fl, PW'(m_ph), g, g, y, r};
   endfunction

   // One clock of the intersection rules: each state lasts its duration, green may end early.
   function automatic void model_step(input bit fe, input logic [NP-1:0] pr);
      bit   others = 0;
      bit   leave = 0;
      mst_t nx = m_st;
      int   nph = m_ph;
      bit   nlit = m_lit;
      for (int i = 0; i < NP; i++) if (m_pend[i] && i != m_ph) others = 1;
      case (m_st)
         M_RED: if (m_age == AC-1) begin
            leave = 1;
            if (fe) begin nx = M_FLS; nlit = 1; end
            else begin nx = M_GRN; nph = m_started ? (m_ph + 1) % NP : 0; end
            m_started = 1;
         end
         M_GRN: if (m_age == GC-1 || (m_age >= MG-1 && others)) begin leave = 1; nx = M_YEL; end
         M_YEL: if (m_age == YC-1) begin leave = 1; nx = M_RED; end
         M_FLS: if (m_age == FC-1) begin
            leave = 1;
            if (!fe) nx = M_RED;
            else     nlit = !m_lit;
         end
         default: ;
      endcase
      for (int i = 0; i < NP; i++)
         if (pr[i] && !(m_st == M_GRN && i == m_ph)) m_pend[i] = 1;
      if (nx == M_GRN && m_st != M_GRN) m_pend[nph] = 0;
      m_st = nx; m_ph = nph; m_lit = nlit;
      m_age = leave ? 0 : m_age + 1;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.v = model_out();
      e.c = cyc;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t          e;
      logic [OW-1:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {flashing, phase, walk, lamp_g, lamp_y, lamp_r};
            checks++;
            if (got !== e.v) begin
               errors++;
               $display("FAIL lamps cyc=%0d actual=%h required=%h", e.c, got, e.v);
            end
            checks++;
            if ($countones(lamp_g) > 1) begin
               errors++;
               $display("FAIL one_green cyc=%0d actual lamp_g=%b required at most one bit", e.c, lamp_g);
            end
         end
      end
   end

   seg_t segs[5] = '{
      '{300, 0,  0, 1'b0},
      '{400, 10, 0, 1'b0},
      '{400, 40, 0, 1'b1},
      '{500, 5,  2, 1'b0},
      '{400, 20, 3, 1'b1}
   };

   initial begin
      int            rst_hold;
      bit            yel_done;
      logic [OW-1:0] got;
      model_reset();
      rst_hold = 0;
      repeat (3) begin
         @(posedge clk); #1; cyc++;
         push_exp();
      end
      rst = 1'b1;

      foreach (segs[s]) begin
         yel_done = 0;
         for (int n = 0; n < segs[s].cycles; n++) begin
            @(posedge clk); #1; cyc++;
            if (rst) model_step(flash_en, ped_req);
            else     model_reset();
            if (rst_hold > 0) begin
               rst_hold--;
               if (rst_hold == 0) rst = 1'b1;
            end else if (segs[s].rst_yel && !yel_done && n > 50 && m_st == M_YEL) begin
               yel_done = 1;
               rst = 1'b0;
               #1;
               model_reset();
               got = {flashing, phase, walk, lamp_g, lamp_y, lamp_r};
               checks++;
               if (got !== model_out()) begin
                  errors++;
                  $display("FAIL async_reset cyc=%0d actual=%h required=%h", cyc, got, model_out());
               end
               rst_hold = 2;
            end
            push_exp();
            for (int i = 0; i < NP; i++)
               ped_req[i] = rst && ($urandom_range(99, 0) < segs[s].ped_pct);
            if ($urandom_range(99, 0) < segs[s].flash_pct) flash_en = ~flash_en;
            if (segs[s].flash_pct == 0) flash_en = 1'b0;
         end
      end

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d pending expectations required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
